// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Runs the instruction-memory read handshake for each fetch request, holds
//   the returned word in a fetch buffer (fbuf) and loads the IR, sign-extended
//   immediate and jump-concat registers under the control FSM's write strobes.
//
// Configuration macro: FETCH_TIMEOUT_EN
//   defined   : a 4-bit wait counter bounds WAIT to TIMEOUT cycles; on expiry the
//               unit enters the terminal ERR state and raises sticky fetch_err.
//   undefined : WAIT persists until mem_ack, ERR is unreachable, fetch_err = 0.
//
// Ports
//   clk, reset_n         clock, synchronous active-low reset
//   pc                   address of the instruction to fetch
//   fetch_req            single-cycle fetch request
//   IR_WE/SE_WE/CONCAT_WE  load IR / se_imm / concat from fbuf
//   mem_rdata, mem_ack   memory read data and completion
//   mem_addr, mem_rd     registered read address and strobe
//   instr, IR_ALU_OP     opcode and funct, combinational from fbuf
//   rs, rt, rd           register fields from IR
//   se_imm, concat       immediate and jump-target registers
//   ir_valid             fbuf holds a word fetched since reset
//   fetch_busy           high while waiting for memory
//   fetch_err            sticky timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT    = 15,
    parameter logic [31:0] RESET_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    input  logic        fetch_req,
    input  logic        IR_WE,
    input  logic        SE_WE,
    input  logic        CONCAT_WE,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [5:0]  instr,
    output logic [5:0]  IR_ALU_OP,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] se_imm,
    output logic [31:0] concat,
    output logic        ir_valid,
    output logic        fetch_busy,
    output logic        fetch_err
);

    typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

    state_e      state_q, state_d;
    logic [31:0] fbuf_q, fbuf_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] se_imm_q, se_imm_d;
    logic [31:0] concat_q, concat_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        ir_valid_q, ir_valid_d;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);
    logic [3:0] cnt_q, cnt_d;
    logic       fetch_err_q, fetch_err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        fbuf_d     = fbuf_q;
        ir_d       = ir_q;
        se_imm_d   = se_imm_q;
        concat_d   = concat_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        ir_valid_d = ir_valid_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
`endif

        // Strobes sample the current fbuf, so a load coinciding with a capture
        // sees the previous word.
        if (IR_WE)     ir_d     = fbuf_q;
        if (SE_WE)     se_imm_d = {{16{fbuf_q[15]}}, fbuf_q[15:0]};
        if (CONCAT_WE) concat_d = {pc[31:28], fbuf_q[25:0], 2'b00};

        unique case (state_q)
            StIdle: begin
                if (fetch_req) begin
                    mem_addr_d = pc;
                    mem_rd_d   = 1'b1;
                    state_d    = StWait;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d      = 4'd0;
`endif
                end
            end
            StWait: begin
                // Ack wins over a timeout in the same cycle.
                if (mem_ack) begin
                    fbuf_d     = mem_rdata;
                    ir_valid_d = 1'b1;
                    mem_rd_d   = 1'b0;
                    state_d    = StIdle;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    mem_rd_d    = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = StErr;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            StErr: begin
                mem_rd_d = 1'b0;
            end
            default: begin
                state_d  = StIdle;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            fbuf_q     <= RESET_WORD;
            ir_q       <= RESET_WORD;
            se_imm_q   <= 32'h0;
            concat_q   <= 32'h0;
            mem_addr_q <= 32'h0;
            mem_rd_q   <= 1'b0;
            ir_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= 4'd0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fbuf_q     <= fbuf_d;
            ir_q       <= ir_d;
            se_imm_q   <= se_imm_d;
            concat_q   <= concat_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            ir_valid_q <= ir_valid_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // Opcode/funct come straight from fbuf so the FSM can decode before IR_WE.
    assign instr      = fbuf_q[31:26];
    assign IR_ALU_OP  = fbuf_q[5:0];
    assign rs         = ir_q[25:21];
    assign rt         = ir_q[20:16];
    assign rd         = ir_q[15:11];
    assign se_imm     = se_imm_q;
    assign concat     = concat_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign ir_valid   = ir_valid_q;
    assign fetch_busy = (state_q == StWait);

    logic unused_ir;
    assign unused_ir = ^{ir_q[31:26], ir_q[10:0]};

endmodule
